inst_fetch: RTL

Instruction fetch stage of the 16-bit pipeline: owns the PC, issues in-order read requests to instruction memory over a valid/ready request and valid-only response channel, and buffers returned words. It presents `{if_pc, if_inst}` to the decode stage through a valid/ready handshake. It is the producing end of the fetch→decode interface and also accepts branch redirects that flush in-flight fetches.

---
 rtl/inst_fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/inst_fetch.sv | 120 ++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: bus widths,
// reset polarity, the NOP encoding and the buffered fetch entry.
package inst_fetch_pkg;

    typedef logic [15:0] InstAddrBus;
    typedef logic [15:0] InstBus;

    localparam logic   RstEnable = 1'b1;
    localparam InstBus InstNop   = 16'h0000;

    typedef struct packed {
        InstAddrBus pc;
        InstBus     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular buffer with flush. Push and pop may coincide at any
// occupancy, including full.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_wdata,
    output logic [WIDTH-1:0]             o_rdata,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst == RstEnable || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone decide validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order credit-limited reads
// to instruction memory, and buffers {pc, inst} for decode.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter InstAddrBus RESET_PC   = 16'h0000,
    parameter int         FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req_valid,
    input  logic       imem_req_ready,
    output InstAddrBus imem_req_addr,
    input  logic       imem_rsp_valid,
    input  InstBus     imem_rsp_data,
    output logic       if_valid,
    input  logic       id_ready,
    output InstAddrBus if_pc,
    output InstBus     if_inst,
    input  logic       redirect,
    input  InstAddrBus redirect_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    InstAddrBus    r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic          w_in_rst;
    logic          w_rsp_take;
    logic          w_keep;
    logic          w_pop;
    logic          w_req_fire;
    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic [CW-1:0] w_fifo_count;
    logic [SW-1:0] w_credit_used;
    InstAddrBus    w_pcq_head;
    logic          w_pcq_full;
    logic          w_pcq_empty;
    logic [CW-1:0] w_pcq_count;
    fetch_entry_t  w_push_entry;
    fetch_entry_t  w_head;
    logic          w_unused;

    assign w_in_rst   = (rst == RstEnable);
    assign w_rsp_take = imem_rsp_valid && !w_in_rst && (r_outstanding != '0);
    assign w_keep     = w_rsp_take && !redirect && (r_discard == '0);

    assign if_valid = !w_in_rst && !redirect && !w_fifo_empty;
    assign w_pop    = if_valid && id_ready;
    assign if_pc    = if_valid ? w_head.pc   : '0;
    assign if_inst  = if_valid ? w_head.inst : InstNop;

    // A slot being popped this cycle is free before any new request can return.
    assign w_credit_used  = SW'(r_outstanding) + SW'(w_fifo_count) - SW'(w_pop);
    assign imem_req_valid = !w_in_rst && !redirect && (w_credit_used < SW'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign w_push_entry = '{pc: w_pcq_head, inst: imem_rsp_data};
    assign w_unused     = &{1'b0, w_fifo_full, w_pcq_full, w_pcq_empty, w_pcq_count};

    always_ff @(posedge clk) begin
        if (w_in_rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (redirect)        r_pc <= redirect_pc;
            else if (w_req_fire) r_pc <= r_pc + 16'd1;

            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);

            // Everything still in flight at a redirect is stale, including earlier discards.
            if (redirect)
                r_discard <= r_outstanding - CW'(w_rsp_take);
            else if (w_rsp_take && r_discard != '0)
                r_discard <= r_discard - CW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(InstAddrBus))
    ) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect),
        .i_push  (w_req_fire),
        .i_pop   (w_keep),
        .i_wdata (r_pc),
        .o_rdata (w_pcq_head),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty),
        .o_count (w_pcq_count)
    );

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_inst_buf (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect),
        .i_push  (w_keep),
        .i_pop   (w_pop),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (w_in_rst)
        !(imem_rsp_valid && r_outstanding == '0));

endmodule
